// File: rtl/source_pump_sequencer_if.sv
// Request/status bundle between the protocol controller and the Source pump sequencer.
//   req_valid / req_ready / req_strokes : dispense request handshake and stroke count
//   abort                               : stop the running dispense
//   valve / inlet_open                  : pump valves {v3,v2,v1} (1 = closed), inlet (1 = open)
//   busy / strokes_done / done / aborted: transaction status and completion
// master = controller side, slave = sequencer side.
interface source_pump_sequencer_if #(
   parameter int unsigned STROKE_W = 8
) ();
   logic                req_valid;
   logic                req_ready;
   logic [STROKE_W-1:0] req_strokes;
   logic                abort;
   logic [2:0]          valve;
   logic                inlet_open;
   logic                busy;
   logic [STROKE_W-1:0] strokes_done;
   logic                done;
   logic                aborted;

   modport master (
      output req_valid, req_strokes, abort,
      input  req_ready, valve, inlet_open, busy, strokes_done, done, aborted
   );

   modport slave (
      input  req_valid, req_strokes, abort,
      output req_ready, valve, inlet_open, busy, strokes_done, done, aborted
   );
endinterface

// File: rtl/source_pump_sequencer.sv
// Source pump sequencer: drives the three-valve peristaltic pump and the inlet
// valve feeding the shared Source channel, dispensing a requested number of
// pump strokes per accepted request.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : request handshake, abort, valve/inlet drive and status (slave side)
// All outputs come straight from flops, decoded from the next state.
module source_pump_sequencer #(
   parameter int unsigned PHASE_CYCLES = 4,
   parameter int unsigned STROKE_W     = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   source_pump_sequencer_if.slave  bus
);

   localparam int unsigned DWELL_W = 8;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(PHASE_CYCLES - 1);
   localparam logic [2:0] LAST_STEP = 3'd5;
   localparam logic [2:0] VALVE_ALL_CLOSED = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRIME  = 3'd1,
      S_PUMP   = 3'd2,
      S_SETTLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                r_state,   w_state_nxt;
   logic [DWELL_W-1:0]    r_dwell,   w_dwell_nxt;
   logic [2:0]            r_step,    w_step_nxt;
   logic [STROKE_W-1:0]   r_target,  w_target_nxt;
   logic [STROKE_W-1:0]   r_strokes, w_strokes_nxt;
   logic                  r_aborted, w_aborted_nxt;
   logic [2:0]            r_valve,   w_valve_nxt;
   logic                  r_inlet,   w_inlet_nxt;
   logic                  r_ready,   w_ready_nxt;
   logic                  r_busy,    w_busy_nxt;
   logic                  r_done,    w_done_nxt;

   logic                  w_dwell_end;
   logic [STROKE_W-1:0]   w_strokes_inc;

   // Peristaltic wave: each step differs from its neighbours (and 5 -> 0) in one valve.
   function automatic logic [2:0] pump_pattern(input logic [2:0] step);
      case (step)
         3'd0:    pump_pattern = 3'b011;
         3'd1:    pump_pattern = 3'b001;
         3'd2:    pump_pattern = 3'b101;
         3'd3:    pump_pattern = 3'b100;
         3'd4:    pump_pattern = 3'b110;
         3'd5:    pump_pattern = 3'b010;
         default: pump_pattern = 3'b111;
      endcase
   endfunction

   assign w_dwell_end   = (r_dwell == DWELL_LAST);
   assign w_strokes_inc = r_strokes + STROKE_W'(1);

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_dwell   <= '0;
         r_step    <= '0;
         r_target  <= '0;
         r_strokes <= '0;
         r_aborted <= 1'b0;
         r_valve   <= VALVE_ALL_CLOSED;
         r_inlet   <= 1'b0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_dwell   <= w_dwell_nxt;
         r_step    <= w_step_nxt;
         r_target  <= w_target_nxt;
         r_strokes <= w_strokes_nxt;
         r_aborted <= w_aborted_nxt;
         r_valve   <= w_valve_nxt;
         r_inlet   <= w_inlet_nxt;
         r_ready   <= w_ready_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // Next-state sequencing, then output decode from the next state.
   always_comb begin
      w_state_nxt   = r_state;
      w_dwell_nxt   = r_dwell;
      w_step_nxt    = r_step;
      w_target_nxt  = r_target;
      w_strokes_nxt = r_strokes;
      w_aborted_nxt = r_aborted;
      w_valve_nxt   = VALVE_ALL_CLOSED;
      w_inlet_nxt   = 1'b0;
      w_ready_nxt   = 1'b0;
      w_busy_nxt    = 1'b1;
      w_done_nxt    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               w_target_nxt  = bus.req_strokes;
               w_strokes_nxt = '0;
               w_aborted_nxt = 1'b0;
               w_dwell_nxt   = '0;
               w_step_nxt    = '0;
               w_state_nxt   = (bus.req_strokes == '0) ? S_DONE : S_PRIME;
            end
         end

         S_PRIME: begin
            if (bus.abort) begin
               w_aborted_nxt = 1'b1;
               w_dwell_nxt   = '0;
               w_state_nxt   = S_SETTLE;
            end else if (w_dwell_end) begin
               w_dwell_nxt = '0;
               w_step_nxt  = '0;
               w_state_nxt = S_PUMP;
            end else begin
               w_dwell_nxt = r_dwell + DWELL_W'(1);
            end
         end

         S_PUMP: begin
            if (w_dwell_end && (r_step == LAST_STEP)) begin
               // A stroke finishing on the abort cycle still counts.
               w_strokes_nxt = w_strokes_inc;
               w_dwell_nxt   = '0;
               w_step_nxt    = '0;
               if (bus.abort || (w_strokes_inc == r_target)) begin
                  w_aborted_nxt = r_aborted | bus.abort;
                  w_state_nxt   = S_SETTLE;
               end
            end else if (bus.abort) begin
               // Partial stroke is dropped from the count.
               w_aborted_nxt = 1'b1;
               w_dwell_nxt   = '0;
               w_state_nxt   = S_SETTLE;
            end else if (w_dwell_end) begin
               w_dwell_nxt = '0;
               w_step_nxt  = r_step + 3'd1;
            end else begin
               w_dwell_nxt = r_dwell + DWELL_W'(1);
            end
         end

         S_SETTLE: begin
            if (w_dwell_end) begin
               w_dwell_nxt = '0;
               w_state_nxt = S_DONE;
            end else begin
               w_dwell_nxt = r_dwell + DWELL_W'(1);
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      case (w_state_nxt)
         S_IDLE: begin
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
         end
         S_PRIME: begin
            w_inlet_nxt = 1'b1;
         end
         S_PUMP: begin
            w_inlet_nxt = 1'b1;
            w_valve_nxt = pump_pattern(w_step_nxt);
         end
         S_DONE: begin
            w_done_nxt = 1'b1;
         end
         default: begin
            w_valve_nxt = VALVE_ALL_CLOSED;
         end
      endcase
   end

   assign bus.req_ready    = r_ready;
   assign bus.valve        = r_valve;
   assign bus.inlet_open   = r_inlet;
   assign bus.busy         = r_busy;
   assign bus.strokes_done = r_strokes;
   assign bus.done         = r_done;
   assign bus.aborted      = r_aborted;

endmodule

// File: tb/tb_source_pump_sequencer.sv
// Bench for source_pump_sequencer: directed scenarios plus randomized
// transactions, checked cycle by cycle against a per-transaction expected trace.
module tb_source_pump_sequencer;

   localparam int unsigned P        = 4;
   localparam int unsigned STROKE_W = 8;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   source_pump_sequencer_if #(.STROKE_W(STROKE_W)) bus ();

   source_pump_sequencer #(
      .PHASE_CYCLES(P),
      .STROKE_W    (STROKE_W)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  pat [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
   logic [14:0] exp_q [$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] mk(input logic [2:0] v, input logic inl, input logic bsy,
                                      input logic rdy, input logic dn, input int sd);
      mk = {v, inl, bsy, rdy, dn, 8'(sd)};
   endfunction

   function automatic logic [14:0] obs_vec();
      obs_vec = {bus.valve, bus.inlet_open, bus.busy, bus.req_ready, bus.done, bus.strokes_done};
   endfunction

   // Expected outputs for cycles t=1..len after the accept edge; abort driven during cycle a.
   task automatic build_trace(input int n, input int a, output int len,
                              output int fin_sd, output bit fin_ab);
      int pump_end;
      exp_q.delete();
      exp_q.push_back(15'd0);
      if (n > 0) begin
         for (int c = 0; c < int'(P); c++) exp_q.push_back(mk(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 0));
         for (int k = 0; k < n; k++)
            for (int s = 0; s < 6; s++)
               for (int c = 0; c < int'(P); c++)
                  exp_q.push_back(mk(pat[s], 1'b1, 1'b1, 1'b0, 1'b0, k));
      end
      pump_end = exp_q.size() - 1;
      fin_sd = n;
      fin_ab = 1'b0;
      if (a >= 1 && a <= pump_end) begin
         fin_ab = 1'b1;
         fin_sd = (a >= int'(P)) ? (a - int'(P)) / (6 * int'(P)) : 0;
         while (exp_q.size() > a + 1) void'(exp_q.pop_back());
      end
      if (n > 0)
         for (int c = 0; c < int'(P); c++) exp_q.push_back(mk(3'b111, 1'b0, 1'b1, 1'b0, 1'b0, fin_sd));
      exp_q.push_back(mk(3'b111, 1'b0, 1'b1, 1'b0, 1'b1, fin_sd));
      len = exp_q.size() - 1;
   endtask

   task automatic check_idle(input string tag, input int sd, input bit ab);
      check_eq({tag, "_vec"}, 32'(obs_vec()), 32'(mk(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, sd)));
      check_eq({tag, "_aborted"}, 32'(bus.aborted), 32'(ab));
   endtask

   // One transaction from IDLE; optionally raise the next request during DONE.
   task automatic run_txn(input int n, input int a, input bit chain, input int next_n);
      int len, fs;
      bit fa;
      build_trace(n, a, len, fs, fa);
      bus.req_valid   = 1'b1;
      bus.req_strokes = STROKE_W'(n);
      bus.abort       = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      for (int t = 1; t <= len; t++) begin
         check_eq($sformatf("n%0d_a%0d_t%0d", n, a, t), 32'(obs_vec()), 32'(exp_q[t]));
         if (t == len) begin
            check_eq($sformatf("n%0d_done_strokes", n), 32'(bus.strokes_done), 32'(fs));
            check_eq($sformatf("n%0d_done_aborted", n), 32'(bus.aborted), 32'(fa));
            bus.req_valid   = chain;
            bus.req_strokes = STROKE_W'(next_n);
            bus.abort       = 1'($urandom_range(0, 1));
         end else begin
            bus.req_valid   = 1'($urandom_range(0, 1));
            bus.req_strokes = STROKE_W'($urandom);
            bus.abort       = (t == a);
         end
         @(posedge clk); #1;
      end
      check_idle($sformatf("n%0d_after", n), fs, fa);
      bus.abort = 1'b0;
      if (!chain) bus.req_valid = 1'b0;
   endtask

   initial begin
      int n, a, nn;
      bit ch;
      total = 0;
      bad   = 0;
      bus.req_valid   = 1'b0;
      bus.req_strokes = '0;
      bus.abort       = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset", 0, 1'b0);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check_idle("idle_hold", 0, 1'b0);
      end

      run_txn(2, 0, 1'b0, 0);
      run_txn(0, 0, 1'b0, 0);
      run_txn(3, int'(P) + 6 * int'(P) + 3 * int'(P) + 2, 1'b0, 0);
      run_txn(1, 7 * int'(P), 1'b0, 0);
      run_txn(1, 0, 1'b1, 2);
      run_txn(2, 0, 1'b1, 0);
      run_txn(0, 0, 1'b0, 0);

      // Reset in the middle of the second stroke.
      bus.req_valid   = 1'b1;
      bus.req_strokes = STROKE_W'(2);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (7 * P + 2) @(posedge clk);
      #1;
      check_eq("mid_pump_strokes", 32'(bus.strokes_done), 32'd1);
      check_eq("mid_pump_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_idle("mid_reset", 0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 40; i++) begin
         n  = $urandom_range(0, 4);
         a  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (2 + 6 * n) * int'(P) + 2) : 0;
         ch = 1'($urandom_range(0, 1));
         nn = $urandom_range(0, 4);
         run_txn(n, a, ch, nn);
         if (ch) run_txn(nn, 0, 1'b0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
